uart_rx_8x: RTL
===============

Name: uart_rx_8x

Overview:
- UART receiver; counterpart of the existing uart_tx. Recovers 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) from the serial input.
- Timing comes from the existing oversampling baud_generator instance: one baud_tick per 1/8 bit, i.e. 8 ticks per bit, BAUD_DIV 651 at 50 MHz for 9600 baud.
- Received bytes go to downstream logic over a valid/ready holding register, with frame-error and overrun pulses.

Parameters:
- OVERSAMPLE, 8: baud_tick pulses per bit period. Legal values are powers of two, 4 or greater.
- DATA_BITS, 8: data bits per frame, received LSB first.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- baud_tick, input, 1: one-clk-wide strobe at OVERSAMPLE x baud rate.
- rx_serial, input, 1: asynchronous serial line; idles high.
- rx_data, output, DATA_BITS: last accepted byte; stable while rx_valid=1.
- rx_valid, output, 1: byte available; level-held until consumed.
- rx_ready, input, 1: consumer accepts the byte on the clk where rx_valid & rx_ready.
- frame_error, output, 1: one-clk pulse; stop bit sampled low.
- overrun, output, 1: one-clk pulse; good frame completed while rx_valid still 1.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rx_data=0, rx_valid=0, frame_error=0, overrun=0.
  - Internals: state=IDLE, counters=0, synchronizer flops=1.
- Input path: rx_serial passes through a 2-flop synchronizer (rx_s). 2-clk latency; all decisions use rx_s.
- Phase counter ph, width log2(OVERSAMPLE):
  - Advances only on baud_tick.
  - Samples are taken at ph = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (3, 4, 5 for 8x).
  - Bit value is the 2-of-3 majority, resolved on the tick where ph = OVERSAMPLE/2+1.
  - ph wraps from OVERSAMPLE-1 to 0; that tick ends the bit period.
- State machine (all transitions occur on baud_tick only):
  - IDLE: on a tick with rx_s=0, go to START with ph=1 (the detecting tick counts as phase 0). Otherwise stay in IDLE.
  - START: if the majority resolves to 1, this is a false start; go to IDLE and clear ph. Otherwise, at the end of the bit go to DATA with bit index=0.
  - DATA: the resolved bit shifts into shift_reg[DATA_BITS-1] while the register shifts right, so the first bit lands in bit 0. At the end of bit index DATA_BITS-1, go to STOP.
  - STOP: the decision is made at majority resolve time, not at the end of the bit, so back-to-back frames are tolerated.
    - Majority 1 and rx_valid=0 (after this clk's handshake): load rx_data with shift_reg, set rx_valid=1, go to IDLE.
    - Majority 1 and rx_valid=1 with no handshake this clk: pulse overrun, keep the old rx_data and rx_valid, drop the new byte, go to IDLE.
    - Majority 0: pulse frame_error, drop the byte, go to BREAK.
  - BREAK: wait for a tick with rx_s=1, then go to IDLE. This prevents a held-low line from re-triggering as new frames.
- Handshake:
  - rx_valid clears on the clk after rx_valid & rx_ready.
  - rx_ready while rx_valid=0 is ignored.
  - If a handshake and a good-stop load fall in the same clk, the load wins: rx_valid stays 1, rx_data takes the new byte, and no overrun is raised.
- Latency: rx_valid rises 1 clk after the STOP resolve tick, about 9.6 bit periods after the start edge for 8N1 at 8x.
- baud_tick=0 permanently: state freezes; the synchronizer still runs.
- Reset mid-frame: immediate return to IDLE with reset values. The partial frame is lost; no error pulse.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams IDLE/START/DATA/STOP/BREAK.
  - Default OVERSAMPLE and DATA_BITS.
  - Sample-phase constants derived from OVERSAMPLE.
  - uart_tx reuses the frame-format constants.
- One sub-module, sync_2ff: 2-flop synchronizer with reset value 1, instantiated for rx_serial.
- The baud_generator stays external and is not instantiated inside this block.

Test Plan:
- Bench drives baud_tick every 4 clks (32 clks/bit). Send 0x41 with rx_ready=1 -> rx_data=0x41, rx_valid high for exactly 1 clk, no error pulses.
- Send 0xA5 with rx_ready=0 -> rx_valid stays 1 and rx_data=0x5A is never seen. Then send 0x3C -> overrun pulses once and rx_data remains 0xA5. Raise rx_ready -> rx_valid drops the next clk.
- Send a frame with stop bit forced low (data 0xFF) -> frame_error pulses once, rx_valid stays 0. Line held low for 40 bit periods -> no further events. Line released, then send 0x55 -> rx_data=0x55.
- 12-clk low glitch on an idle line (majority high at ph 3..5) -> no state leaves IDLE for more than 1 bit, no rx_valid, no errors.
- Data bits with single-sample glitches at ph=4 on each bit, sending 0x00 -> majority vote yields rx_data=0x00.
- Deassert rst_n mid-DATA of 0x81, release, then send 0x7E -> all outputs 0 during reset, next rx_data=0x7E, no error pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format defaults, receiver state encoding
// and oversampling phase helpers used by uart_rx_8x and uart_tx.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 8;
  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int START_BITS         = 1;
  localparam int STOP_BITS          = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  // Three samples straddle the bit centre; the last one resolves the vote.
  function automatic int sample_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int sample_mid(input int os);
    return os / 2;
  endfunction

  function automatic int sample_hi(input int os);
    return os / 2 + 1;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle
// UART line never looks like a start bit coming out of reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_8x.sv
// Oversampling 8N1 UART receiver with 2-of-3 majority bit recovery and a
// valid/ready holding register that reports frame errors and overruns.
module uart_rx_8x
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [PH_W-1:0]  PH_LO    = PH_W'(sample_lo(OVERSAMPLE));
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(sample_mid(OVERSAMPLE));
  localparam logic [PH_W-1:0]  PH_HI    = PH_W'(sample_hi(OVERSAMPLE));
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 maj;

  uart_state_t          state_reg,       state_next;
  logic [PH_W-1:0]      ph_reg,          ph_next;
  logic [IDX_W-1:0]     idx_reg,         idx_next;
  logic [1:0]           votes_reg,       votes_next;
  logic [DATA_BITS-1:0] shift_reg,       shift_next;
  logic [DATA_BITS-1:0] rx_data_reg,     rx_data_next;
  logic                 rx_valid_reg,    rx_valid_next;
  logic                 frame_error_reg, frame_error_next;
  logic                 overrun_reg,     overrun_next;

  sync_2ff #(.WIDTH(1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // Only meaningful on the tick where ph_reg == PH_HI.
  assign maj = majority3(votes_reg[0], votes_reg[1], rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ph_reg          <= '0;
      idx_reg         <= '0;
      votes_reg       <= '0;
      shift_reg       <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ph_reg          <= ph_next;
      idx_reg         <= idx_next;
      votes_reg       <= votes_next;
      shift_reg       <= shift_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      frame_error_reg <= frame_error_next;
      overrun_reg     <= overrun_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ph_next          = ph_reg;
    idx_next         = idx_reg;
    votes_next       = votes_reg;
    shift_next       = shift_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg & ~rx_ready;
    frame_error_next = 1'b0;
    overrun_next     = 1'b0;

    if (baud_tick) begin
      ph_next = ph_reg + 1'b1;
      if (ph_reg == PH_LO)  votes_next[0] = rx_s;
      if (ph_reg == PH_MID) votes_next[1] = rx_s;

      unique case (state_reg)
        IDLE: begin
          ph_next = '0;
          if (!rx_s) begin
            state_next = START;
            ph_next    = PH_W'(1);
          end
        end

        START: begin
          if (ph_reg == PH_HI && maj) begin
            state_next = IDLE;
            ph_next    = '0;
          end else if (ph_reg == PH_LAST) begin
            state_next = DATA;
            idx_next   = '0;
          end
        end

        DATA: begin
          if (ph_reg == PH_HI) shift_next = {maj, shift_reg[DATA_BITS-1:1]};
          if (ph_reg == PH_LAST) begin
            if (idx_reg == IDX_LAST) state_next = STOP;
            else                     idx_next   = idx_reg + 1'b1;
          end
        end

        // Decided mid-stop-bit so a following start edge is not missed.
        STOP: begin
          if (ph_reg == PH_HI) begin
            ph_next = '0;
            if (maj) begin
              state_next = IDLE;
              if (!rx_valid_reg || rx_ready) begin
                rx_data_next  = shift_reg;
                rx_valid_next = 1'b1;
              end else begin
                overrun_next = 1'b1;
              end
            end else begin
              state_next       = BREAK;
              frame_error_next = 1'b1;
            end
          end
        end

        BREAK: begin
          ph_next = '0;
          if (rx_s) state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
          ph_next    = '0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;

endmodule
